// File: rtl/keypad_scan_nibble.sv
// keypad_scan_nibble: scans a 4x4 active-low keypad, debounces presses and releases, and emits
// the {row, col} code with a one-cycle read strobe. Define KEYPAD_SYNC_EN to synchronize cols_in.
module keypad_scan_nibble #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols_in,
    output logic [3:0] rows_out,
    output logic [3:0] nibble,
    output logic       read,
    output logic       key_down
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {StScan, StDeb, StHeld} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      row_q, row_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      cand_q, cand_d;
    logic [3:0]      nibble_q, nibble_d;
    logic            read_q, read_d;
    logic            key_down_q, key_down_d;

    logic [3:0]      cs;
    logic            sample;
    logic            hit;
    logic [1:0]      col;
    logic [3:0]      code;
    logic [CntW-1:0] cnt_inc;
    logic            cnt_full;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= cols_in;
            sync2_q <= sync1_q;
        end
    end

    assign cs = sync2_q;
`else
    assign cs = cols_in;
`endif

    // Lowest-index closed column wins when several are pressed on one row.
    always_comb begin
        col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!cs[i]) col = 2'(i);
        end
    end

    assign hit      = ~&cs;
    assign code     = {row_q, col};
    assign sample   = (div_q == DivW'(SCAN_DIV - 1));
    assign cnt_inc  = cnt_q + 1'b1;
    assign cnt_full = (cnt_inc == CntW'(DEBOUNCE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StScan;
            div_q      <= '0;
            row_q      <= 2'd0;
            cnt_q      <= '0;
            cand_q     <= 4'h0;
            nibble_q   <= 4'h0;
            read_q     <= 1'b0;
            key_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            nibble_q   <= nibble_d;
            read_q     <= read_d;
            key_down_q <= key_down_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = sample ? '0 : div_q + 1'b1;
        row_d      = row_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        nibble_d   = nibble_q;
        read_d     = 1'b0;
        key_down_d = key_down_q;

        unique case (state_q)
            StScan: begin
                if (sample) begin
                    if (hit) begin
                        cand_d  = code;
                        cnt_d   = CntW'(1);
                        state_d = StDeb;
                        if (DEBOUNCE == 1) begin
                            nibble_d   = code;
                            read_d     = 1'b1;
                            key_down_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = StHeld;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            StDeb: begin
                if (sample) begin
                    if (hit && (code == cand_q)) begin
                        if (cnt_full) begin
                            nibble_d   = cand_q;
                            read_d     = 1'b1;
                            key_down_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = StHeld;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        row_d   = row_q + 1'b1;
                        state_d = StScan;
                    end
                end
            end
            StHeld: begin
                // Any key seen while held restarts the release count; a second key is ignored.
                if (sample) begin
                    if (hit) begin
                        cnt_d = '0;
                    end else if (cnt_full) begin
                        cnt_d      = '0;
                        key_down_d = 1'b0;
                        row_d      = row_q + 1'b1;
                        state_d    = StScan;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_comb begin
        rows_out = ~(4'b0001 << row_q);
        nibble   = nibble_q;
        read     = read_q;
        key_down = key_down_q;
    end

endmodule

// File: tb/tb_keypad_scan_nibble.sv
// Scoreboard bench for keypad_scan_nibble: a keypad model drives cols_in from rows_out, expected
// strobes (cycle, code) are queued at stimulus time and matched when read rises.
module tb_keypad_scan_nibble;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cols_in;
    logic [3:0]  rows_out;
    logic [3:0]  nibble;
    logic        read;
    logic        key_down;
    logic [15:0] pressed = '0;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    logic read_prev = 1'b0;

    typedef struct {
        int         cyc;
        logic [3:0] nib;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    keypad_scan_nibble dut (
        .clk      (clk),
        .reset    (reset),
        .cols_in  (cols_in),
        .rows_out (rows_out),
        .nibble   (nibble),
        .read     (read),
        .key_down (key_down)
    );

    // Keypad: key bit (r*4 + c) pulls column c low while row r is driven.
    always_comb begin
        cols_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows_out[r] && pressed[r*4+c]) cols_in[c] = 1'b0;
            end
        end
    end

    // Label seen at a negedge = index of the next rising edge; edge 0 is the first with reset low.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (label %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (read) begin
            check("read_single", int'(read_prev), 0);
            check("read_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("read_cycle", cyc, mon_e.cyc);
                check("read_nibble", nibble, mon_e.nib);
            end
        end
        read_prev = read;
    end

    task automatic wait_label(input int k);
        @(negedge clk);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] keys);
        @(negedge clk);
        reset   = 1'b1;
        pressed = keys;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input int c, input logic [3:0] n);
        exp_t e;
        e.cyc = c;
        e.nib = n;
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rows;

        // 1: reset values, then free-running row scan
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rows", rows_out, 4'b1110);
        check("rst_read", read, 0);
        check("rst_nibble", nibble, 0);
        check("rst_key_down", key_down, 0);
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) wait_label(k);
            exp_rows = 4'b0001 << ((k / 4) % 4);
            exp_rows = ~exp_rows;
            check("scan_rows", rows_out, exp_rows);
        end

        // 2: row 2 col 1 held from reset
        do_reset(16'h0200);
        push(20, 4'h9);
        wait_label(19);
        check("s2_key_down_pre", key_down, 0);
        wait_label(20);
        check("s2_key_down", key_down, 1);
        wait_label(21);
        check("s2_read_off", read, 0);
        pressed = '0;
        wait_label(31);
        check("s2_held", key_down, 1);
        wait_label(32);
        check("s2_released", key_down, 0);
        check("s2_row_adv", rows_out, 4'b0111);

        // 3: row 1 col 3 bounces away at the second sample, then a stable re-press
        do_reset(16'h0000);
        wait_label(5);
        pressed = 16'h0080;
        wait_label(9);
        pressed = '0;
        wait_label(12);
        check("s3_row_resume", rows_out, 4'b1011);
        check("s3_no_key_down", key_down, 0);
        wait_label(24);
        pressed = 16'h0080;
        push(36, 4'h7);
        wait_label(37);
        check("s3_nibble_hold", nibble, 7);
        check("s3_key_down", key_down, 1);

        // 5: reset during DEB after two matches; nibble 7 must clear, no strobe
        pressed = '0;
        wait_label(48);
        pressed = 16'h0200;
        wait_label(55);
        check("s5_nibble_pre", nibble, 7);
        wait_label(56);
        reset   = 1'b1;
        pressed = '0;
        @(negedge clk);
        check("s5_rows", rows_out, 4'b1110);
        check("s5_read", read, 0);
        check("s5_nibble", nibble, 0);
        check("s5_key_down", key_down, 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("s5_no_pending", exp_q.size(), 0);

        // 4: two columns on row 0, hold, release, re-press
        do_reset(16'h0005);
        push(12, 4'h0);
        wait_label(12);
        check("s4_key_down", key_down, 1);
        wait_label(20);
        check("s4_still_held", key_down, 1);
        pressed = '0;
        wait_label(31);
        check("s4_held_31", key_down, 1);
        wait_label(32);
        check("s4_released", key_down, 0);
        wait_label(40);
        pressed = 16'h0005;
        push(56, 4'h0);
        wait_label(57);
        check("s4_repress", key_down, 1);
        pressed = '0;

        // 6: key applied at cycle 0, then at cycle 10
        do_reset(16'h0000);
        pressed = 16'h0200;
        push(20, 4'h9);
        wait_label(21);
        check("s6_key_down", key_down, 1);
        pressed = '0;
        wait_label(33);
        check("s6_released", key_down, 0);
        do_reset(16'h0000);
        wait_label(10);
        pressed = 16'h0200;
`ifdef KEYPAD_SYNC_EN
        push(36, 4'h9);
`else
        push(20, 4'h9);
`endif
        wait_label(40);
        check("s6_late_key_down", key_down, 1);
        pressed = '0;
        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
